sync_fifo_param: RTL and testbench



---
 rtl/sync_fifo_param.sv | 95 +++++++++
 tb/tb_sync_fifo_param.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with optional first-word fall-through, almost-full/empty
// thresholds, synchronous flush and sticky overflow/underflow flags.
module sync_fifo_param #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter bit FWFT       = 1'b0,
  parameter int AFULL_THR  = (1 << ADDR_W) - 4,
  parameter int AEMPTY_THR = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] din,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full,
  output logic              almost_empty,
  output logic              almost_full,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic              underflow
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_L    = (ADDR_W+1)'(AFULL_THR);
  localparam logic [ADDR_W:0] AE_L    = (ADDR_W+1)'(AEMPTY_THR);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic              rd_ok, wr_ok;
  logic [ADDR_W:0]   level_next;

  // A full FIFO still takes a push when the same cycle pops a word.
  assign rd_ok = rd_en && !empty;
  assign wr_ok = wr_en && (!full || rd_ok);

  always_comb begin
    level_next = level;
    if (flush) level_next = '0;
    else       level_next = level + (ADDR_W+1)'(wr_ok) - (ADDR_W+1)'(rd_ok);
  end

  // Storage is never reset or flushed; only the pointers are.
  always_ff @(posedge clk) begin
    if (wr_ok && !flush) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      level        <= level_next;
      empty        <= (level_next == '0);
      full         <= (level_next == DEPTH_L);
      almost_empty <= (level_next <= AE_L);
      almost_full  <= (level_next >= AF_L);
      if (flush) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end else begin
        if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
        if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
        if (wr_en && !wr_ok) overflow  <= 1'b1;
        if (rd_en && !rd_ok) underflow <= 1'b1;
      end
    end
  end

  generate
    if (FWFT) begin : g_fwft
      assign dout = mem[rd_ptr];
    end else begin : g_reg
      logic [DATA_W-1:0] dout_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     dout_q <= '0;
        else if (flush) dout_q <= '0;
        else if (rd_ok) dout_q <= mem[rd_ptr];
      end
      assign dout = dout_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench: a registered-read and an FWFT instance driven by the same stimulus.
module tb_sync_fifo_param;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
  logic [7:0] din = '0;
  logic [7:0] dout0, dout1;
  logic       empty0, full0, ae0, af0, ovf0, unf0;
  logic       empty1, full1, ae1, af1, ovf1, unf1;
  logic [4:0] level0, level1;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  sync_fifo_param #(.DATA_W(8), .ADDR_W(4), .FWFT(1'b0), .AFULL_THR(12), .AEMPTY_THR(2)) u_reg (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(dout0), .empty(empty0), .full(full0), .almost_empty(ae0), .almost_full(af0),
    .level(level0), .overflow(ovf0), .underflow(unf0));

  sync_fifo_param #(.DATA_W(8), .ADDR_W(4), .FWFT(1'b1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(dout1), .empty(empty1), .full(full1), .almost_empty(ae1), .almost_full(af1),
    .level(level1), .overflow(ovf1), .underflow(unf1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock with the given inputs; returns 1 ns after the edge with inputs idle.
  task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic f = 1'b0);
    wr_en = w; din = d; rd_en = r; flush = f;
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0;
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] exp_dout;
    logic       w, r, rok, wok;

    // Reset held for 3 cycles
    repeat (3) @(posedge clk);
    #1;
    chk("rst_level", level0, 0);
    chk("rst_empty", empty0, 1);
    chk("rst_full", full0, 0);
    chk("rst_ae", ae0, 1);
    chk("rst_af", af0, 0);
    chk("rst_ovf", ovf0, 0);
    chk("rst_unf", unf0, 0);
    chk("rst_dout", dout0, 0);
    rst_n = 1'b1;

    // Asynchronous reset mid-operation at level 5
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(i), 1'b0);
    chk("pre_rst_level", level0, 5);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_level", level0, 0);
    chk("async_rst_empty", empty0, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Fill 0x00..0x0F
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 8'(i), 1'b0);
      chk($sformatf("fill_level%0d", i), level0, i + 1);
      chk($sformatf("fill_ae%0d", i), ae0, (i + 1) <= 2);
      chk($sformatf("fill_af%0d", i), af0, (i + 1) >= 12);
      chk($sformatf("fill_full%0d", i), full0, (i + 1) == 16);
    end

    // Push+pop while full: level stays 16, no overflow
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 8'hA0 + 8'(i), 1'b1);
      chk("pass_level", level0, 16);
      chk("pass_ovf", ovf0, 0);
      chk("pass_dout", dout0, i);
    end

    // Push on full without pop
    cyc(1'b1, 8'hFF, 1'b0);
    chk("ovf_set", ovf0, 1);
    chk("ovf_level", level0, 16);

    // Drain: 0x08..0x0F then 0xA0..0xA7
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 8'h00, 1'b1);
      chk("drain_dout", dout0, (i < 8) ? 8 + i : 8'hA0 + i - 8);
    end
    chk("drain_empty", empty0, 1);
    chk("drain_level", level0, 0);
    cyc(1'b0, 8'h00, 1'b1);
    chk("unf_set", unf0, 1);
    chk("unf_dout_hold", dout0, 8'hA7);

    // Flush clears sticky flags
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("flush_ovf_clr", ovf0, 0);
    chk("flush_unf_clr", unf0, 0);
    chk("flush_dout", dout0, 0);

    // Simultaneous push/pop on empty
    cyc(1'b1, 8'h3C, 1'b1);
    chk("we_level", level0, 1);
    chk("we_unf", unf0, 1);
    chk("we_empty", empty0, 0);
    cyc(1'b0, 8'h00, 1'b1);
    chk("we_dout", dout0, 8'h3C);
    chk("we_empty2", empty0, 1);

    // Flush with push/pop pending at level 9, overflow set
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 17; i++) cyc(1'b1, 8'hB0 + 8'(i), 1'b0);
    for (int i = 0; i < 7; i++) cyc(1'b0, 8'h00, 1'b1);
    chk("pf_level", level0, 9);
    chk("pf_ovf", ovf0, 1);
    cyc(1'b1, 8'hEE, 1'b1, 1'b1);
    chk("fl_level", level0, 0);
    chk("fl_empty", empty0, 1);
    chk("fl_ovf", ovf0, 0);
    chk("fl_unf", unf0, 0);
    chk("fl_ae", ae0, 1);
    cyc(1'b1, 8'h11, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    chk("fl_discard", dout0, 8'h11);
    chk("fl_empty2", empty0, 1);

    // FWFT instance
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    cyc(1'b1, 8'h55, 1'b0);
    chk("fwft_first", dout1, 8'h55);
    chk("fwft_nempty", empty1, 0);
    cyc(1'b1, 8'h66, 1'b0);
    chk("fwft_hold", dout1, 8'h55);
    cyc(1'b0, 8'h00, 1'b1);
    chk("fwft_next", dout1, 8'h66);
    chk("fwft_level", level1, 1);
    cyc(1'b0, 8'h00, 1'b1);
    chk("fwft_empty", empty1, 1);

    // Interleaved traffic across pointer wrap, against a queue model
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    exp_dout = 8'h00;
    for (int i = 0; i < 40; i++) begin
      w = (i % 3) != 2;
      r = (i % 4) != 0;
      rok = r && (q.size() > 0);
      wok = w && (q.size() < 16 || rok);
      if (rok) exp_dout = q.pop_front();
      if (wok) q.push_back(8'h40 + 8'(i));
      cyc(w, 8'h40 + 8'(i), r);
      chk($sformatf("wrap_dout%0d", i), dout0, exp_dout);
      chk($sformatf("wrap_level%0d", i), level0, q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
